// File: rtl/uart_reg_ctrl_if.sv
// Byte-stream input and register-bank output bundle for uart_reg_ctrl.
// Master side is the UART receiver plus the register consumers.
// Slave side is the command sequencer itself.
interface uart_reg_ctrl_if #(
    parameter int WORDSZ = 8,
    parameter int NREGS  = 4
) ();
    localparam int AW = $clog2(NREGS);

    logic                      rx_en;
    logic                      rx_valid;
    logic [WORDSZ-1:0]         rx_data;
    logic                      rx_break;
    logic [NREGS*WORDSZ-1:0]   regs_out;
    logic                      wr_pulse;
    logic [AW-1:0]             wr_addr;
    logic                      err_pulse;
    logic [7:0]                err_count;
    logic                      busy;

    modport master (
        output rx_en, rx_valid, rx_data, rx_break,
        input  regs_out, wr_pulse, wr_addr, err_pulse, err_count, busy
    );

    modport slave (
        input  rx_en, rx_valid, rx_data, rx_break,
        output regs_out, wr_pulse, wr_addr, err_pulse, err_count, busy
    );
endinterface

// File: rtl/uart_reg_ctrl.sv
// Parses HDR/ADDR/DATA/CHK frames from the UART byte stream into register writes.
// Latency: one cycle from the CHK byte (or break/timeout) to wr_pulse/err_pulse.
// No backpressure: every byte is consumed on its rx_valid strobe; bad frames are dropped and counted.
module uart_reg_ctrl #(
    parameter int          WORDSZ      = 8,
    parameter int          NREGS       = 4,
    parameter int          TIMEOUT_CYC = 1_000_000,
    parameter logic [7:0]  HDR         = 8'hA5
) (
    input  logic             clk,
    input  logic             rst,
    uart_reg_ctrl_if.slave   bus
);
    localparam int AW = $clog2(NREGS);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {
        ST_HUNT = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_CHK  = 2'd3
    } state_t;

    state_t             state;
    logic [WORDSZ-1:0]  addr_q;
    logic [WORDSZ-1:0]  data_q;
    logic [TW-1:0]      tmo_cnt;
    logic [WORDSZ-1:0]  regs_q [NREGS];
    logic               wr_pulse_q;
    logic [AW-1:0]      wr_addr_q;
    logic               err_pulse_q;
    logic [7:0]         err_cnt_q;

    logic               in_frame;
    logic               brk_abort;
    logic               tmo_hit;
    logic               frame_ok;
    logic               wr_evt;
    logic               err_evt;

    // Event decode in priority order: enable, break, byte, timeout.
    always_comb begin
        in_frame  = (state != ST_HUNT);
        brk_abort = bus.rx_en && in_frame && bus.rx_break;
        tmo_hit   = (tmo_cnt == TW'(TIMEOUT_CYC - 1));
        frame_ok  = (bus.rx_data == (WORDSZ'(HDR) ^ addr_q ^ data_q)) &&
                    (addr_q[WORDSZ-1:AW] == '0);
        wr_evt    = bus.rx_en && !brk_abort && bus.rx_valid && (state == ST_CHK) && frame_ok;
        err_evt   = brk_abort ||
                    (bus.rx_en && in_frame && !bus.rx_break && bus.rx_valid &&
                     (state == ST_CHK) && !frame_ok) ||
                    (bus.rx_en && in_frame && !bus.rx_break && !bus.rx_valid && tmo_hit);
    end

    // Frame FSM with inter-byte timeout counter; counter idles at zero in HUNT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_HUNT;
            addr_q  <= '0;
            data_q  <= '0;
            tmo_cnt <= '0;
        end else if (!bus.rx_en || brk_abort) begin
            state   <= ST_HUNT;
            tmo_cnt <= '0;
        end else if (bus.rx_valid) begin
            tmo_cnt <= '0;
            case (state)
                ST_HUNT: if (bus.rx_data == WORDSZ'(HDR)) state <= ST_ADDR;
                ST_ADDR: begin
                    addr_q <= bus.rx_data;
                    state  <= ST_DATA;
                end
                ST_DATA: begin
                    data_q <= bus.rx_data;
                    state  <= ST_CHK;
                end
                default: state <= ST_HUNT;
            endcase
        end else if (in_frame) begin
            if (tmo_hit) begin
                state   <= ST_HUNT;
                tmo_cnt <= '0;
            end else begin
                tmo_cnt <= tmo_cnt + TW'(1);
            end
        end
    end

    // Register bank and write strobe; contents change only on a validated frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
            wr_pulse_q <= 1'b0;
            wr_addr_q  <= '0;
        end else begin
            wr_pulse_q <= wr_evt;
            if (wr_evt) begin
                regs_q[addr_q[AW-1:0]] <= data_q;
                wr_addr_q              <= addr_q[AW-1:0];
            end
        end
    end

    // Error strobe and saturating reject counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_pulse_q <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            err_pulse_q <= err_evt;
            if (err_evt && (err_cnt_q != 8'hFF)) err_cnt_q <= err_cnt_q + 8'd1;
        end
    end

    for (genvar g = 0; g < NREGS; g++) begin : g_pack
        assign bus.regs_out[g*WORDSZ +: WORDSZ] = regs_q[g];
    end

    assign bus.wr_pulse  = wr_pulse_q;
    assign bus.wr_addr   = wr_addr_q;
    assign bus.err_pulse = err_pulse_q;
    assign bus.err_count = err_cnt_q;
    assign bus.busy      = (state != ST_HUNT);
endmodule

// File: tb/tb_uart_reg_ctrl.sv
// Directed bench for uart_reg_ctrl: framing, checksum, range, timeout, break, enable, saturation, reset.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// Short timeout (50 cycles) keeps the timeout cases fast.
module tb_uart_reg_ctrl;
    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    uart_reg_ctrl_if #(.WORDSZ(8), .NREGS(4)) bus ();

    uart_reg_ctrl #(
        .WORDSZ(8), .NREGS(4), .TIMEOUT_CYC(50), .HDR(8'hA5)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        @(negedge clk);
        bus.rx_valid = 1'b0;
    endtask

    // Four bytes on consecutive cycles; returns in the cycle after CHK.
    task automatic send_frame(input logic [7:0] h, input logic [7:0] a,
                              input logic [7:0] d, input logic [7:0] c);
        logic [7:0] seq [4];
        seq[0] = h; seq[1] = a; seq[2] = d; seq[3] = c;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            bus.rx_data  = seq[i];
            bus.rx_valid = 1'b1;
            @(negedge clk);
        end
        bus.rx_valid = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] b2b [8];

        rst          = 1'b1;
        bus.rx_en    = 1'b1;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        bus.rx_break = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_regs", bus.regs_out, 32'h0);
        chk("rst_wr_pulse", bus.wr_pulse, 0);
        chk("rst_wr_addr", bus.wr_addr, 0);
        chk("rst_err_pulse", bus.err_pulse, 0);
        chk("rst_err_count", bus.err_count, 0);
        chk("rst_busy", bus.busy, 0);
        rst = 1'b0;

        // Valid write to reg2
        send_frame(8'hA5, 8'h02, 8'h3C, 8'h9B);
        chk("wr_pulse", bus.wr_pulse, 1);
        chk("wr_addr", bus.wr_addr, 2);
        chk("wr_regs", bus.regs_out, 32'h003C_0000);
        chk("wr_err_count", bus.err_count, 0);
        chk("wr_err_pulse", bus.err_pulse, 0);
        @(negedge clk);
        chk("wr_pulse_one_cycle", bus.wr_pulse, 0);
        chk("wr_busy_after", bus.busy, 0);

        // Bad checksum, then the corrected frame
        send_frame(8'hA5, 8'h01, 8'h55, 8'h00);
        chk("badchk_err_pulse", bus.err_pulse, 1);
        chk("badchk_err_count", bus.err_count, 1);
        chk("badchk_wr_pulse", bus.wr_pulse, 0);
        chk("badchk_regs", bus.regs_out, 32'h003C_0000);
        @(negedge clk);
        chk("badchk_err_one_cycle", bus.err_pulse, 0);
        send_frame(8'hA5, 8'h01, 8'h55, 8'hF1);
        chk("fix_wr_pulse", bus.wr_pulse, 1);
        chk("fix_wr_addr", bus.wr_addr, 1);
        chk("fix_regs", bus.regs_out, 32'h003C_5500);

        // Out-of-range address with correct checksum
        send_frame(8'hA5, 8'h07, 8'h11, 8'hB3);
        chk("oor_err_pulse", bus.err_pulse, 1);
        chk("oor_err_count", bus.err_count, 2);
        chk("oor_wr_pulse", bus.wr_pulse, 0);
        chk("oor_regs", bus.regs_out, 32'h003C_5500);

        // Timeout: 49 idle cycles still in frame, 50th aborts
        send_byte(8'hA5);
        chk("tmo_busy_after_hdr", bus.busy, 1);
        send_byte(8'h00);
        repeat (49) @(negedge clk);
        chk("tmo_busy_49", bus.busy, 1);
        chk("tmo_err_49", bus.err_pulse, 0);
        @(negedge clk);
        chk("tmo_err_pulse", bus.err_pulse, 1);
        chk("tmo_busy_fall", bus.busy, 0);
        chk("tmo_err_count", bus.err_count, 3);

        // Byte arriving on the expiry cycle is processed normally
        send_byte(8'hA5);
        repeat (48) @(negedge clk);
        send_byte(8'h00);
        chk("edge_busy", bus.busy, 1);
        chk("edge_err_pulse", bus.err_pulse, 0);
        chk("edge_err_count", bus.err_count, 3);
        send_byte(8'hAA);
        send_byte(8'h0F);
        chk("edge_wr_pulse", bus.wr_pulse, 1);
        chk("edge_regs", bus.regs_out, 32'h003C_55AA);

        // Back-to-back frames with no idle gap
        b2b[0] = 8'hA5; b2b[1] = 8'h00; b2b[2] = 8'h11; b2b[3] = 8'hB4;
        b2b[4] = 8'hA5; b2b[5] = 8'h03; b2b[6] = 8'h22; b2b[7] = 8'h84;
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            bus.rx_data  = b2b[i];
            bus.rx_valid = 1'b1;
            @(negedge clk);
            if (i == 3) begin
                chk("b2b_first_wr_pulse", bus.wr_pulse, 1);
                chk("b2b_first_wr_addr", bus.wr_addr, 0);
            end
        end
        bus.rx_valid = 1'b0;
        chk("b2b_second_wr_pulse", bus.wr_pulse, 1);
        chk("b2b_second_wr_addr", bus.wr_addr, 3);
        chk("b2b_regs", bus.regs_out, 32'h223C_5511);

        // Break mid-frame aborts with an error; break in HUNT is ignored
        send_byte(8'hA5);
        send_byte(8'h03);
        @(negedge clk);
        bus.rx_break = 1'b1;
        @(negedge clk);
        bus.rx_break = 1'b0;
        chk("brk_err_pulse", bus.err_pulse, 1);
        chk("brk_busy", bus.busy, 0);
        chk("brk_err_count", bus.err_count, 4);
        @(negedge clk);
        bus.rx_break = 1'b1;
        @(negedge clk);
        bus.rx_break = 1'b0;
        chk("brk_hunt_err_pulse", bus.err_pulse, 0);
        chk("brk_hunt_err_count", bus.err_count, 4);

        // Enable low mid-frame: back to HUNT silently, bytes ignored
        send_byte(8'hA5);
        send_byte(8'h03);
        @(negedge clk);
        bus.rx_en = 1'b0;
        @(negedge clk);
        chk("en_busy", bus.busy, 0);
        chk("en_err_pulse", bus.err_pulse, 0);
        chk("en_err_count", bus.err_count, 4);
        send_frame(8'hA5, 8'h03, 8'h77, 8'hD1);
        chk("en_off_wr_pulse", bus.wr_pulse, 0);
        chk("en_off_busy", bus.busy, 0);
        chk("en_off_regs", bus.regs_out, 32'h223C_5511);
        bus.rx_en = 1'b1;
        send_frame(8'hA5, 8'h03, 8'h77, 8'hD1);
        chk("en_on_wr_pulse", bus.wr_pulse, 1);
        chk("en_on_regs", bus.regs_out, 32'h773C_5511);

        // Saturation of the reject counter
        for (int n = 0; n < 260; n++) send_frame(8'hA5, 8'h00, 8'h00, 8'h00);
        chk("sat_err_count", bus.err_count, 255);
        chk("sat_regs", bus.regs_out, 32'h773C_5511);

        // Asynchronous reset mid-frame, checked before any clock edge
        send_byte(8'hA5);
        send_byte(8'h01);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_regs", bus.regs_out, 32'h0);
        chk("arst_busy", bus.busy, 0);
        chk("arst_err_count", bus.err_count, 0);
        chk("arst_wr_addr", bus.wr_addr, 0);
        chk("arst_wr_pulse", bus.wr_pulse, 0);
        chk("arst_err_pulse", bus.err_pulse, 0);
        @(negedge clk);
        rst = 1'b0;
        send_frame(8'hA5, 8'h01, 8'h55, 8'hF1);
        chk("post_rst_regs", bus.regs_out, 32'h0000_5500);
        chk("post_rst_err_count", bus.err_count, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
